// File: rtl/fifo_read_stage_pkg.sv
// -----------------------------------------------------------------------------
// fifo_read_stage_pkg
//   Shared types and constants for the FIFO read stage.
//   state_t      : fill level of the two-entry output buffer (head + skid).
//   BUF_ENTRIES  : number of words the output buffer can hold.
// -----------------------------------------------------------------------------
package fifo_read_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam int unsigned BUF_ENTRIES = 2;

endpackage

// File: rtl/fifo_read_stage.sv
// -----------------------------------------------------------------------------
// fifo_read_stage
//   Drains a push/pop FIFO through its pop/empty/read_data interface and
//   presents the words as a registered valid/ready stream. A head register
//   drives the output; a skid register absorbs the one extra word popped while
//   downstream stalls, so fifo_pop depends only on registered state and
//   fifo_empty, never on down_ready. Sustains one word per cycle.
//
// Parameters
//   width           data word width in bits (>= 1)
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous reset, active-low
//   flush           (FIFO_READ_STAGE_FLUSH_EN only) synchronous flush, active-high
//   fifo_empty      FIFO empty flag
//   fifo_read_data  FIFO head word, valid while fifo_empty = 0
//   fifo_pop        pop request; FIFO head advances on the next rising edge
//   down_valid      downstream word valid
//   down_ready      downstream accepts word
//   down_data       downstream word
//
// Build option
//   FIFO_READ_STAGE_FLUSH_EN  adds the flush port, which discards both
//                             buffered words and blocks pop/fire for a cycle.
// -----------------------------------------------------------------------------
module fifo_read_stage
  import fifo_read_stage_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FIFO_READ_STAGE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_read_data,
  output logic             fifo_pop,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [width-1:0] down_data
);

  state_t             state;
  state_t             state_nxt;
  logic               en;
  logic [width-1:0]   head_p1;
  logic [width-1:0]   skid_p1;
  logic               vld_p1;
  logic               fire;
  logic               do_pop;
  logic               head_ld;
  logic               head_sel_skid;
  logic               skid_ld;
  logic               blocked;

`ifdef FIFO_READ_STAGE_FLUSH_EN
  assign blocked = flush;
`else
  assign blocked = 1'b0;
`endif

  // Pop whenever a buffer slot is free; the skid slot guarantees a word
  // popped during a stall always has somewhere to land.
  assign fifo_pop   = en & ~fifo_empty & (state != ST_TWO) & ~blocked;
  assign do_pop     = fifo_pop;
  assign vld_p1     = (state != ST_EMPTY);
  assign fire       = vld_p1 & down_ready & ~blocked;
  assign down_valid = vld_p1;
  assign down_data  = head_p1;

  always_comb begin
    state_nxt     = state;
    head_ld       = 1'b0;
    head_sel_skid = 1'b0;
    skid_ld       = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (do_pop) begin
          state_nxt = ST_ONE;
          head_ld   = 1'b1;
        end
      end
      ST_ONE: begin
        if (do_pop && fire) begin
          head_ld = 1'b1;
        end else if (do_pop) begin
          state_nxt = ST_TWO;
          skid_ld   = 1'b1;
        end else if (fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (fire) begin
          state_nxt     = ST_ONE;
          head_ld       = 1'b1;
          head_sel_skid = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a known empty buffer.
        state_nxt = ST_EMPTY;
      end
    endcase
    if (blocked) begin
      state_nxt = ST_EMPTY;
      head_ld   = 1'b0;
      skid_ld   = 1'b0;
    end
  end

  // Stage p1: output buffer registers (head drives down_data, skid holds overflow)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_EMPTY;
      en      <= 1'b0;
      head_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      state <= state_nxt;
      en    <= 1'b1;
      if (head_ld) begin
        head_p1 <= head_sel_skid ? skid_p1 : fifo_read_data;
      end
      if (skid_ld) begin
        skid_p1 <= fifo_read_data;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_stage.sv
module tb_fifo_read_stage;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush_s = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_read_data = '0;
  logic         fifo_pop;
  logic         down_valid;
  logic         down_ready = 1'b0;
  logic [W-1:0] down_data;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_err = 0;
  int           pops = 0;
  logic         pop_arm = 1'b0;
  logic         hold_prev = 1'b0;
  logic [W-1:0] hold_data = '0;

  fifo_read_stage #(.width(W)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef FIFO_READ_STAGE_FLUSH_EN
    .flush          (flush_s),
`endif
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_pop       (fifo_pop),
    .down_valid     (down_valid),
    .down_ready     (down_ready),
    .down_data      (down_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_read_data = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic load(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    refresh();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // FIFO model: the pop seen before the edge retires the head just after it.
  always begin
    @(posedge clk);
    #1;
    if (pop_arm && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    refresh();
  end

  // Monitor: scoreboard on every fire, plus hold-stability under backpressure.
  always @(negedge clk) begin
    logic [W-1:0] w;
    pop_arm = fifo_pop;
    if (rst) begin
      if (hold_prev) begin
        chk("hold_valid", 32'(down_valid), 32'd1);
        chk("hold_data", 32'(down_data), 32'(hold_data));
      end
      if (down_valid && down_ready && !flush_s) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL scoreboard: got unexpected word %0h expected none", down_data);
        end else begin
          w = exp_q.pop_front();
          chk("scoreboard", 32'(down_data), 32'(w));
        end
      end
      hold_prev = down_valid && !down_ready && !flush_s;
      hold_data = down_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    int p0;
    // Reset / startup, FIFO already non-empty
    #1 rst = 1'b0;
    down_ready = 1'b1;
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    #1;
    chk("rst_data", 32'(down_data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_pop", 32'(fifo_pop), 32'd0);
      chk("rst_valid", 32'(down_valid), 32'd0);
    end
    rst = 1'b1;
    chk("start_pop_pre", 32'(fifo_pop), 32'd0);
    step(1);
    chk("start_pop_e1", 32'(fifo_pop), 32'd1);
    chk("start_valid_e1", 32'(down_valid), 32'd0);
    // Streaming
    step(1); chk("stream_v0", 32'(down_valid), 32'd1); chk("stream_d0", 32'(down_data), 32'h11);
    step(1); chk("stream_d1", 32'(down_data), 32'h22);
    step(1); chk("stream_d2", 32'(down_data), 32'h33);
    step(1); chk("stream_d3", 32'(down_data), 32'h44);
    step(1);
    chk("stream_end_valid", 32'(down_valid), 32'd0);
    chk("stream_end_pop", 32'(fifo_pop), 32'd0);

    // Backpressure
    down_ready = 1'b0;
    p0 = pops;
    load(8'hA0); load(8'hA1); load(8'hA2); load(8'hA3);
    step(5);
    chk("bp_pops", 32'(pops - p0), 32'd2);
    chk("bp_pop_off", 32'(fifo_pop), 32'd0);
    chk("bp_valid", 32'(down_valid), 32'd1);
    chk("bp_data", 32'(down_data), 32'hA0);
    down_ready = 1'b1;
    step(1); chk("bp_d1", 32'(down_data), 32'hA1); chk("bp_v1", 32'(down_valid), 32'd1);
    step(1); chk("bp_d2", 32'(down_data), 32'hA2); chk("bp_v2", 32'(down_valid), 32'd1);
    step(1); chk("bp_d3", 32'(down_data), 32'hA3); chk("bp_v3", 32'(down_valid), 32'd1);
    step(1); chk("bp_end_valid", 32'(down_valid), 32'd0);

    // Random ready
    for (int i = 0; i < 200; i++) load(W'($urandom_range(0, 255)));
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) begin
      down_ready = ($urandom_range(0, 1) == 1);
      step(1);
    end
    chk("random_drained", 32'(exp_q.size()), 32'd0);
    down_ready = 1'b1;
    step(2);
    chk("random_idle_valid", 32'(down_valid), 32'd0);

    // Mid-stream reset while holding two words
    down_ready = 1'b0;
    load(8'hB0); load(8'hB1); load(8'hB2);
    step(3);
    chk("mr_full_data", 32'(down_data), 32'hB0);
    rst = 1'b0;
    #1;
    chk("mr_valid", 32'(down_valid), 32'd0);
    chk("mr_data", 32'(down_data), 32'd0);
    chk("mr_pop", 32'(fifo_pop), 32'd0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    step(2);
    rst = 1'b1;
    down_ready = 1'b1;
    step(1);
    chk("mr_pop_e1", 32'(fifo_pop), 32'd1);
    step(1);
    chk("mr_next_valid", 32'(down_valid), 32'd1);
    chk("mr_next_data", 32'(down_data), 32'hB2);
    step(1);
    chk("mr_end_valid", 32'(down_valid), 32'd0);

`ifdef FIFO_READ_STAGE_FLUSH_EN
    // Flush while holding two words
    down_ready = 1'b0;
    load(8'h55); load(8'h66); load(8'h77);
    step(2);
    chk("fl_head", 32'(down_data), 32'h55);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    flush_s = 1'b1;
    down_ready = 1'b1;
    #1;
    chk("fl_pop_off", 32'(fifo_pop), 32'd0);
    step(1);
    flush_s = 1'b0;
    chk("fl_valid_off", 32'(down_valid), 32'd0);
    step(1);
    chk("fl_next_valid", 32'(down_valid), 32'd1);
    chk("fl_next_data", 32'(down_data), 32'h77);
    step(1);
    chk("fl_end_valid", 32'(down_valid), 32'd0);
`endif

    step(2);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
